// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, with a 2-flop input synchronizer and a rdy/ack byte handshake.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int CLKS_TW = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       ack,
  output logic [7:0] data_rx,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  // state     | meaning
  // IDLE      | line idle, waiting for a low rxs
  // START     | half a bit period in, confirm the start bit
  // DATA      | sample 8 data bits at bit-period intervals
  // PARITY    | sample the even-parity bit (parity build only)
  // STOP      | sample the stop bit, deliver or flag the frame
  // WAIT_HIGH | line held low after a bad stop bit; wait for idle
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY     = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  localparam int CW = ($clog2(CLKS_TW) > 16) ? $clog2(CLKS_TW) : 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_TW - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_TW / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          sync1;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_tick;
  logic          stop_sample;
  logic          deliver;
  logic          par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign bit_tick    = (cnt == BIT_LAST);
  assign stop_sample = (state == STOP) && bit_tick;
  assign deliver     = stop_sample && rxs && par_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= din;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= AFTER_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            cnt   <= '0;
            state <= rxs ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && bit_tick) par_bit <= rxs;
      parity_err <= stop_sample && !par_ok;
    end
  end
`endif

  // A byte arriving while rdy is still held is dropped unless ack frees the buffer that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rx   <= 8'h00;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rxs;
      overrun   <= deliver && rdy && !ack;
      if (deliver) begin
        if (!rdy || ack) data_rx <= shreg;
        rdy <= 1'b1;
      end else if (ack) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_TW=16: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;
  localparam int TW = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       ack;
  logic [7:0] data_rx;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLKS_TW(TW)) dut (
    .clk(clk), .rst(rst), .din(din), .ack(ack), .data_rx(data_rx), .rdy(rdy),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   n_ferr = 0, n_ovr = 0, n_perr = 0, n_rise = 0;
  logic rdy_q = 1'b0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    if (parity_err === 1'b1) n_perr++;
    if (rdy === 1'b1 && rdy_q !== 1'b1) n_rise++;
    rdy_q = rdy;
  end

  logic [7:0] m_data;
  logic       m_rdy;
  int         m_ferr = 0, m_ovr = 0, m_perr = 0;

  // Frame-level model: a frame is good when its stop bit is 1 and (parity build) the
  // XOR of data and parity bit is 0; a good frame fills an empty/acked buffer or is lost.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic par,
                             input bit ack_mode);
    bit par_bad;
    par_bad = HAS_PAR && ((^b) != par);
    if (!stop) m_ferr++;
    if (par_bad) m_perr++;
    if (stop && !par_bad) begin
      if (!m_rdy || ack_mode) begin
        m_data = b;
        m_rdy  = 1'b1;
      end else begin
        m_ovr++;
      end
    end else if (ack_mode) begin
      m_rdy = 1'b0;
    end
  endtask

  // Called at a negedge; ack_mode raises ack across the stop bit and drops it once rdy rises.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par,
                            input bit ack_mode, input int hold_low);
    logic prev;
    din = 1'b0;
    repeat (TW) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (TW) @(negedge clk);
    end
    if (HAS_PAR) begin
      din = par;
      repeat (TW) @(negedge clk);
    end
    din  = stop;
    ack  = ack_mode;
    prev = rdy;
    for (int i = 0; i < TW; i++) begin
      @(negedge clk);
      if (ack && rdy && !prev) ack = 1'b0;
      prev = rdy;
    end
    ack = 1'b0;
    repeat (hold_low) @(negedge clk);
    din = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    m_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 1'b1; ack = 1'b0;
    #12;
    checks++;
    if (data_rx !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_rx); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {frame_err, overrun, parity_err});
    end
    @(negedge clk);
    rst = 1'b1;
    m_data = 8'h00; m_rdy = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL post_reset_rdy got %b exp 0", rdy); end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 0);
    model_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    checks++;
    if (rdy !== m_rdy) begin errors++; $display("FAIL basic_rdy got %b exp %b", rdy, m_rdy); end
    checks++;
    if (data_rx !== m_data) begin errors++; $display("FAIL basic_data got %h exp %h", data_rx, m_data); end
    checks++;
    if (n_ferr != m_ferr || n_ovr != m_ovr || n_perr != m_perr) begin
      errors++; $display("FAIL basic_pulses got f%0d o%0d p%0d exp f%0d o%0d p%0d",
                         n_ferr, n_ovr, n_perr, m_ferr, m_ovr, m_perr);
    end
  endtask

  task automatic test_ack();
    ack_pulse();
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", rdy); end
    checks++;
    if (data_rx !== m_data) begin errors++; $display("FAIL ack_data_hold got %h exp %h", data_rx, m_data); end
    ack_pulse();
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL ack_idle got %b exp 0", rdy); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, ^8'h11, 1'b0, 0);
    model_frame(8'h11, 1'b1, ^8'h11, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 0);
    model_frame(8'h3C, 1'b1, ^8'h3C, 1'b0);
    checks++;
    if (n_ovr != m_ovr) begin errors++; $display("FAIL overrun_count got %0d exp %0d", n_ovr, m_ovr); end
    checks++;
    if (data_rx !== m_data) begin errors++; $display("FAIL overrun_data got %h exp %h", data_rx, m_data); end
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1, 0);
    model_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
    checks++;
    if (data_rx !== m_data) begin errors++; $display("FAIL ack_deliver_data got %h exp %h", data_rx, m_data); end
    checks++;
    if (rdy !== m_rdy) begin errors++; $display("FAIL ack_deliver_rdy got %b exp %b", rdy, m_rdy); end
    checks++;
    if (n_ovr != m_ovr) begin errors++; $display("FAIL ack_deliver_ovr got %0d exp %0d", n_ovr, m_ovr); end
    ack_pulse();
  endtask

  task automatic test_glitch();
    int r0;
    r0 = n_rise;
    din = 1'b0;
    repeat (5) @(negedge clk);
    din = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (n_rise != r0 || rdy !== 1'b0) begin
      errors++; $display("FAIL glitch_rdy got rises %0d rdy %b exp 0 0", n_rise - r0, rdy);
    end
    checks++;
    if (n_ferr != m_ferr || n_perr != m_perr) begin
      errors++; $display("FAIL glitch_err got f%0d p%0d exp f%0d p%0d", n_ferr, n_perr, m_ferr, m_perr);
    end
    send_frame(8'h96, 1'b1, ^8'h96, 1'b0, 0);
    model_frame(8'h96, 1'b1, ^8'h96, 1'b0);
    checks++;
    if (data_rx !== m_data || rdy !== m_rdy) begin
      errors++; $display("FAIL glitch_recover got %h/%b exp %h/%b", data_rx, rdy, m_data, m_rdy);
    end
    ack_pulse();
  endtask

  task automatic test_frame_err();
    int r0;
    r0 = n_rise;
    send_frame(8'h5A, 1'b0, ^8'h5A, 1'b0, 100);
    model_frame(8'h5A, 1'b0, ^8'h5A, 1'b0);
    checks++;
    if (n_ferr != m_ferr) begin errors++; $display("FAIL frame_err_count got %0d exp %0d", n_ferr, m_ferr); end
    checks++;
    if (rdy !== 1'b0 || n_rise != r0) begin
      errors++; $display("FAIL frame_err_rdy got %b rises %0d exp 0 0", rdy, n_rise - r0);
    end
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, 0);
    model_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
    checks++;
    if (data_rx !== m_data || n_ferr != m_ferr) begin
      errors++; $display("FAIL frame_err_recover got %h f%0d exp %h f%0d", data_rx, n_ferr, m_data, m_ferr);
    end
  endtask

  task automatic test_reset_mid_frame();
    int r0;
    din = 1'b0;
    repeat (TW) @(negedge clk);
    din = 1'b1;
    repeat (3 * TW) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if (rdy !== 1'b0 || data_rx !== 8'h00) begin
      errors++; $display("FAIL mid_reset_out got %b/%h exp 0/00", rdy, data_rx);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_rdy = 1'b0; m_data = 8'h00;
    repeat (8 * TW) @(negedge clk);
    r0 = n_rise;
    send_frame(8'h42, 1'b1, ^8'h42, 1'b0, 0);
    model_frame(8'h42, 1'b1, ^8'h42, 1'b0);
    checks++;
    if (data_rx !== m_data || rdy !== m_rdy) begin
      errors++; $display("FAIL mid_reset_data got %h/%b exp %h/%b", data_rx, rdy, m_data, m_rdy);
    end
    checks++;
    if (n_rise - r0 != 1) begin errors++; $display("FAIL mid_reset_deliveries got %0d exp 1", n_rise - r0); end
    ack_pulse();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0);
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    checks++;
    if (n_perr != m_perr) begin errors++; $display("FAIL parity_err_count got %0d exp %0d", n_perr, m_perr); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL parity_err_rdy got %b exp 0", rdy); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0);
    model_frame(8'h07, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rdy !== 1'b1 || data_rx !== 8'h07) begin
      errors++; $display("FAIL parity_ok got %b/%h exp 1/07", rdy, data_rx);
    end
    ack_pulse();
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    logic       stop, par;
    bit         ackm;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^b) ^ (HAS_PAR && ($urandom_range(0, 3) == 0));
      ackm = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      send_frame(b, stop, par, ackm, 0);
      model_frame(b, stop, par, ackm);
      checks++;
      if (data_rx !== m_data || rdy !== m_rdy) begin
        errors++; $display("FAIL random_%0d_out got %h/%b exp %h/%b", n, data_rx, rdy, m_data, m_rdy);
      end
      checks++;
      if (n_ferr != m_ferr || n_ovr != m_ovr || n_perr != m_perr) begin
        errors++; $display("FAIL random_%0d_pulses got f%0d o%0d p%0d exp f%0d o%0d p%0d",
                           n, n_ferr, n_ovr, n_perr, m_ferr, m_ovr, m_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
